// File: rtl/reset_pkg.sv
// Shared constants for the board reset sequencer: FSM encoding, reset-cause codes
// and the helpers that size the shared counter and pick the fault cause.
package reset_pkg;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_RELEASE   = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_HOLD      = 2'd3;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Watchdog outranks software, which outranks lock loss.
    function automatic logic [1:0] cause_sel(input logic wdt, input logic sw);
        if (wdt) begin
            return CAUSE_WDT;
        end else if (sw) begin
            return CAUSE_SW;
        end
        return CAUSE_LOCK;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-low clear, used to bring the
// PLL lock indication into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: waits for a stable PLL lock, releases domain resets one
// at a time, and re-asserts them all on watchdog, software request or lock loss.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int LOCK_STABLE = 64,
    parameter int STEP_CYCLES = 16,
    parameter int HOLD_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pll_lock,
    input  logic                   sw_rst_req,
    input  logic                   wdt_expire,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   seq_done,
    output logic                   sw_rst_ack,
    output logic [1:0]             rst_cause
);

    localparam int CNT_MAX = max3(LOCK_STABLE, STEP_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Index must be able to hold NUM_DOMAINS itself once the last domain is out.
    localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STEP_TC  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

    logic                   lock_s;
    logic                   fault;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_out_q;
    logic [NUM_DOMAINS-1:0] rst_n_out_d;
    logic                   seq_done_q;
    logic                   seq_done_d;
    logic                   sw_rst_ack_q;
    logic                   sw_rst_ack_d;
    logic [1:0]             rst_cause_q;
    logic [1:0]             rst_cause_d;

    sync2 u_lock_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (pll_lock),
        .q    (lock_s)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rst_n_out_d  = rst_n_out_q;
        seq_done_d   = seq_done_q;
        sw_rst_ack_d = 1'b0;
        rst_cause_d  = rst_cause_q;

        fault = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) &&
                (wdt_expire || sw_rst_req || !lock_s);

        case (state_q)
            ST_WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_TC) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == STEP_TC) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_n_out_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_RUN;
                        seq_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_TC) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // A fault overrides any release due in the same cycle.
        if (fault) begin
            state_d      = ST_HOLD;
            cnt_d        = '0;
            idx_d        = '0;
            rst_n_out_d  = '0;
            seq_done_d   = 1'b0;
            sw_rst_ack_d = sw_rst_req;
            rst_cause_d  = cause_sel(wdt_expire, sw_rst_req);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            idx_q        <= '0;
            rst_n_out_q  <= '0;
            seq_done_q   <= 1'b0;
            sw_rst_ack_q <= 1'b0;
            rst_cause_q  <= CAUSE_POR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rst_n_out_q  <= rst_n_out_d;
            seq_done_q   <= seq_done_d;
            sw_rst_ack_q <= sw_rst_ack_d;
            rst_cause_q  <= rst_cause_d;
        end
    end

    assign rst_n_out  = rst_n_out_q;
    assign seq_done   = seq_done_q;
    assign sw_rst_ack = sw_rst_ack_q;
    assign rst_cause  = rst_cause_q;

endmodule
